// File: rtl/traffic_pkg.sv
// Shared light-code constants, checker state encoding and phase-order helper.
package traffic_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] LIGHT_GREEN  = 3'b001;
    localparam logic [CODE_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [CODE_W-1:0] LIGHT_RED    = 3'b011;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        G    = 2'd1,
        Y    = 2'd2,
        R    = 2'd3
    } light_state_e;

    // Only successor a phase may legally move to; INIT has none of its own.
    function automatic light_state_e legal_next(input light_state_e s);
        light_state_e n;
        case (s)
            G:       n = Y;
            Y:       n = R;
            R:       n = G;
            default: n = INIT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_monitor_if.sv
// Light-code bus between the intersection controller and its monitor.
interface traffic_monitor_if;
    import traffic_pkg::*;

    logic [CODE_W-1:0] light_ns;
    logic [CODE_W-1:0] light_ew;
    logic              clr_faults;

    modport master (output light_ns, output light_ew, output clr_faults);
    modport slave  (input  light_ns, input  light_ew, input  clr_faults);
endinterface

// File: rtl/light_dir_checker.sv
// Per-direction phase checker: decodes one light code, tracks phase and
// dwell, and raises single-cycle error pulses for the top to accumulate.
module light_dir_checker
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 16,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_YELLOW = 4,
    parameter int unsigned MAX_RED    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  dwell,
    output logic              valid_c,
    output logic              red_c,
    output logic              seq_err_c,
    output logic              timing_err_c,
    output logic              code_err_c,
    output logic              cycle_c
);

    localparam logic [CNT_W-1:0] DWELL_SAT = '1;

    light_state_e     state_q, state_d;
    light_state_e     code_st;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] max_dwell;
    logic [CNT_W-1:0] min_dwell;

    // Decode the sampled code into a phase.
    always_comb begin
        code_st = INIT;
        valid_c = 1'b0;
        case (code)
            LIGHT_GREEN:  begin code_st = G; valid_c = 1'b1; end
            LIGHT_YELLOW: begin code_st = Y; valid_c = 1'b1; end
            LIGHT_RED:    begin code_st = R; valid_c = 1'b1; end
            default:      begin code_st = INIT; valid_c = 1'b0; end
        endcase
        red_c = (code == LIGHT_RED);
    end

    // Dwell bounds for the phase currently held (red has no minimum).
    always_comb begin
        max_dwell = DWELL_SAT;
        min_dwell = '0;
        case (state_q)
            G: begin max_dwell = CNT_W'(MAX_GREEN);  min_dwell = CNT_W'(MIN_GREEN);  end
            Y: begin max_dwell = CNT_W'(MAX_YELLOW); min_dwell = CNT_W'(MIN_YELLOW); end
            R: begin max_dwell = CNT_W'(MAX_RED);    min_dwell = '0;                 end
            default: begin max_dwell = DWELL_SAT;    min_dwell = '0;                 end
        endcase
    end

    // Next phase, dwell and error pulses.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        seq_err_c    = 1'b0;
        timing_err_c = 1'b0;
        code_err_c   = 1'b0;
        cycle_c      = 1'b0;
        if (!valid_c) begin
            code_err_c = 1'b1;
            state_d    = INIT;
            dwell_d    = '0;
        end else if (state_q == INIT) begin
            state_d = code_st;
            dwell_d = CNT_W'(1);
        end else if (code_st == state_q) begin
            // Overrun fires only on the step from max to max+1.
            timing_err_c = (dwell_q == max_dwell) && (dwell_q != DWELL_SAT);
            dwell_d      = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + CNT_W'(1);
        end else begin
            seq_err_c    = (code_st != legal_next(state_q));
            timing_err_c = (dwell_q < min_dwell);
            cycle_c      = (state_q == R) && (code_st == G);
            state_d      = code_st;
            dwell_d      = CNT_W'(1);
        end
    end

    // Phase and dwell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    assign dwell = dwell_q;

endmodule

// File: rtl/traffic_monitor.sv
// Passive monitor of the intersection light bus: per-direction phase
// checking, cross-direction conflict detection, sticky fault reporting.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 16,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_YELLOW = 4,
    parameter int unsigned MAX_RED    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    traffic_monitor_if.slave    bus,
    output logic                fault_conflict,
    output logic                fault_code,
    output logic                fault_seq,
    output logic                fault_timing,
    output logic                fault,
    output logic [1:0]          fault_dir,
    output logic [7:0]          ns_cycles,
    output logic [CNT_W-1:0]    dwell_ns,
    output logic [CNT_W-1:0]    dwell_ew
);

    logic ns_valid_c, ns_red_c, ns_seq_c, ns_tim_c, ns_code_c, ns_cycle_c;
    logic ew_valid_c, ew_red_c, ew_seq_c, ew_tim_c, ew_code_c, ew_cycle_unused;
    logic conflict_c;
    logic [1:0] dir_c;

    light_dir_checker #(
        .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .MAX_RED(MAX_RED)
    ) u_ns (
        .clk(clk), .rst_n(rst_n), .code(bus.light_ns), .dwell(dwell_ns),
        .valid_c(ns_valid_c), .red_c(ns_red_c), .seq_err_c(ns_seq_c),
        .timing_err_c(ns_tim_c), .code_err_c(ns_code_c), .cycle_c(ns_cycle_c)
    );

    light_dir_checker #(
        .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .MAX_RED(MAX_RED)
    ) u_ew (
        .clk(clk), .rst_n(rst_n), .code(bus.light_ew), .dwell(dwell_ew),
        .valid_c(ew_valid_c), .red_c(ew_red_c), .seq_err_c(ew_seq_c),
        .timing_err_c(ew_tim_c), .code_err_c(ew_code_c), .cycle_c(ew_cycle_unused)
    );

    // Both directions showing valid non-red codes at once.
    assign conflict_c = ns_valid_c && ew_valid_c && !ns_red_c && !ew_red_c;
    assign dir_c      = {ew_seq_c | ew_tim_c | ew_code_c, ns_seq_c | ns_tim_c | ns_code_c};

    // Sticky flags: clear replaces history, but new faults on the same edge survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_conflict <= 1'b0;
            fault_code     <= 1'b0;
            fault_seq      <= 1'b0;
            fault_timing   <= 1'b0;
            fault_dir      <= 2'b00;
        end else if (bus.clr_faults) begin
            fault_conflict <= conflict_c;
            fault_code     <= ns_code_c | ew_code_c;
            fault_seq      <= ns_seq_c | ew_seq_c;
            fault_timing   <= ns_tim_c | ew_tim_c;
            fault_dir      <= dir_c;
        end else begin
            fault_conflict <= fault_conflict | conflict_c;
            fault_code     <= fault_code | ns_code_c | ew_code_c;
            fault_seq      <= fault_seq | ns_seq_c | ew_seq_c;
            fault_timing   <= fault_timing | ns_tim_c | ew_tim_c;
            fault_dir      <= fault_dir | dir_c;
        end
    end

    // Completed NS cycles, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_cycles <= 8'd0;
        end else if (ns_cycle_c && (ns_cycles != 8'hFF)) begin
            ns_cycles <= ns_cycles + 8'd1;
        end
    end

    assign fault = fault_conflict | fault_code | fault_seq | fault_timing;

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_traffic_monitor;

    localparam logic [2:0] C_G = 3'b001;
    localparam logic [2:0] C_Y = 3'b010;
    localparam logic [2:0] C_R = 3'b011;

    logic       clk;
    logic       rst_n;
    logic       fault_conflict, fault_code, fault_seq, fault_timing, fault;
    logic [1:0] fault_dir;
    logic [7:0] ns_cycles;
    logic [5:0] dwell_ns, dwell_ew;

    int total = 0;
    int bad   = 0;

    traffic_monitor_if bus ();

    traffic_monitor dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .fault_conflict(fault_conflict), .fault_code(fault_code),
        .fault_seq(fault_seq), .fault_timing(fault_timing), .fault(fault),
        .fault_dir(fault_dir), .ns_cycles(ns_cycles),
        .dwell_ns(dwell_ns), .dwell_ew(dwell_ew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per direction, the phase last seen (as its code, 0 = none)
    // and how many consecutive samples it has been held.
    int         m_ph [2];
    int         m_len[2];
    logic       e_conf, e_code, e_seq, e_tim;
    logic [1:0] e_dir;
    int         e_cyc;

    function automatic int max_of(input int ph);
        return (ph == 1) ? 16 : (ph == 2) ? 4 : 24;
    endfunction

    function automatic int min_of(input int ph);
        return (ph == 1) ? 4 : (ph == 2) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin m_ph[d] = 0; m_len[d] = 0; end
        e_conf = 0; e_code = 0; e_seq = 0; e_tim = 0; e_dir = 2'b00; e_cyc = 0;
    endtask

    task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        logic n_conf, n_code, n_seq, n_tim, hit;
        logic [1:0] n_dir;
        int c;
        n_code = 0; n_seq = 0; n_tim = 0; n_dir = 2'b00;
        for (int d = 0; d < 2; d++) begin
            c   = (d == 0) ? int'(ns) : int'(ew);
            hit = 0;
            if (c < 1 || c > 3) begin
                n_code = 1; hit = 1; m_ph[d] = 0; m_len[d] = 0;
            end else if (m_ph[d] == 0) begin
                m_ph[d] = c; m_len[d] = 1;
            end else if (c == m_ph[d]) begin
                if (m_len[d] == max_of(c)) begin n_tim = 1; hit = 1; end
                if (m_len[d] < 63) m_len[d]++;
            end else begin
                if (c != (m_ph[d] % 3) + 1) begin n_seq = 1; hit = 1; end
                if (m_len[d] < min_of(m_ph[d])) begin n_tim = 1; hit = 1; end
                if (d == 0 && m_ph[d] == 3 && c == 1 && e_cyc < 255) e_cyc++;
                m_ph[d] = c; m_len[d] = 1;
            end
            if (hit) n_dir[d] = 1'b1;
        end
        n_conf = (ns >= 1 && ns <= 3) && (ew >= 1 && ew <= 3) && ns != C_R && ew != C_R;
        if (clr) begin
            e_conf = n_conf; e_code = n_code; e_seq = n_seq; e_tim = n_tim; e_dir = n_dir;
        end else begin
            e_conf |= n_conf; e_code |= n_code; e_seq |= n_seq; e_tim |= n_tim; e_dir |= n_dir;
        end
    endtask

    // Present one sample pair, advance the model, and settle just past the edge.
    task automatic drive(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        bus.light_ns   = ns;
        bus.light_ew   = ew;
        bus.clr_faults = clr;
        model_step(ns, ew, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.clr_faults = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({fault_conflict, fault_code, fault_seq, fault_timing, fault} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000",
                            {fault_conflict, fault_code, fault_seq, fault_timing, fault});
        end
        total++;
        if ({fault_dir, ns_cycles, dwell_ns, dwell_ew} !== 22'd0) begin
            bad++; $display("FAIL reset_counts: dir=%b cyc=%0d dns=%0d dew=%0d want all 0",
                            fault_dir, ns_cycles, dwell_ns, dwell_ew);
        end
        do_reset();
    endtask

    task automatic test_clean_run();
        logic [2:0] ns, ew;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 26; i++) begin
                ns = (i < 10) ? C_G : (i < 12) ? C_Y : C_R;
                ew = (i < 12) ? C_R : (i < 22) ? C_G : (i < 24) ? C_Y : C_R;
                drive(ns, ew, 1'b0);
            end
        end
        total++;
        if (fault !== 1'b0 || fault_dir !== 2'b00) begin
            bad++; $display("FAIL clean_flags: fault=%b dir=%b want 0 00", fault, fault_dir);
        end
        total++;
        if (ns_cycles !== 8'd2) begin
            bad++; $display("FAIL clean_cycles: got %0d want 2", ns_cycles);
        end
        total++;
        if (dwell_ns !== 6'd14 || dwell_ew !== 6'd2) begin
            bad++; $display("FAIL clean_dwell: ns=%0d ew=%0d want 14 2", dwell_ns, dwell_ew);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(C_G, C_G, 1'b0);
        total++;
        if (fault_conflict !== 1'b1 || fault !== 1'b1) begin
            bad++; $display("FAIL conflict_flag: conf=%b fault=%b want 1 1", fault_conflict, fault);
        end
        total++;
        if ({fault_code, fault_seq, fault_timing} !== 3'b000 || fault_dir !== 2'b00) begin
            bad++; $display("FAIL conflict_others: cst=%b dir=%b want 000 00",
                            {fault_code, fault_seq, fault_timing}, fault_dir);
        end
    endtask

    task automatic test_seq_skip();
        do_reset();
        repeat (5) drive(C_G, C_R, 1'b0);
        drive(C_R, C_R, 1'b0);
        total++;
        if (fault_seq !== 1'b1 || fault_dir !== 2'b01 || fault_timing !== 1'b0) begin
            bad++; $display("FAIL seq_skip: seq=%b dir=%b tim=%b want 1 01 0",
                            fault_seq, fault_dir, fault_timing);
        end
        total++;
        if (dwell_ns !== 6'd1) begin
            bad++; $display("FAIL seq_skip_dwell: got %0d want 1", dwell_ns);
        end
    endtask

    task automatic test_green_overrun();
        do_reset();
        repeat (16) drive(C_G, C_R, 1'b0);
        total++;
        if (fault_timing !== 1'b0) begin
            bad++; $display("FAIL overrun_early: got %b want 0", fault_timing);
        end
        drive(C_G, C_R, 1'b0);
        total++;
        if (fault_timing !== 1'b1 || fault_dir !== 2'b01 || dwell_ns !== 6'd17) begin
            bad++; $display("FAIL overrun_edge: tim=%b dir=%b dwell=%0d want 1 01 17",
                            fault_timing, fault_dir, dwell_ns);
        end
        drive(C_Y, C_R, 1'b1);
        total++;
        if (fault !== 1'b0 || fault_dir !== 2'b00) begin
            bad++; $display("FAIL overrun_clear: fault=%b dir=%b want 0 00", fault, fault_dir);
        end
        drive(C_R, C_R, 1'b0);
        total++;
        if (fault_timing !== 1'b1 || fault_dir !== 2'b01 || fault_seq !== 1'b0) begin
            bad++; $display("FAIL short_yellow: tim=%b dir=%b seq=%b want 1 01 0",
                            fault_timing, fault_dir, fault_seq);
        end
    endtask

    task automatic test_invalid_code();
        do_reset();
        drive(C_R, 3'b000, 1'b0);
        total++;
        if (fault_code !== 1'b1 || fault_dir !== 2'b10 || dwell_ew !== 6'd0) begin
            bad++; $display("FAIL invalid_code: code=%b dir=%b dwell=%0d want 1 10 0",
                            fault_code, fault_dir, dwell_ew);
        end
        drive(C_R, C_G, 1'b0);
        total++;
        if (fault_seq !== 1'b0 || fault_conflict !== 1'b0 || dwell_ew !== 6'd1) begin
            bad++; $display("FAIL invalid_reentry: seq=%b conf=%b dwell=%0d want 0 0 1",
                            fault_seq, fault_conflict, dwell_ew);
        end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        drive(C_R, C_Y, 1'b0);
        drive(C_G, C_Y, 1'b0);
        total++;
        if (ns_cycles !== 8'd1 || fault_conflict !== 1'b1) begin
            bad++; $display("FAIL cycle_count: cyc=%0d conf=%b want 1 1", ns_cycles, fault_conflict);
        end
        drive(C_G, C_Y, 1'b1);
        total++;
        if (fault_conflict !== 1'b1) begin
            bad++; $display("FAIL clr_set_wins: got %b want 1", fault_conflict);
        end
        drive(C_G, C_R, 1'b1);
        total++;
        if (fault !== 1'b0 || fault_dir !== 2'b00 || ns_cycles !== 8'd1) begin
            bad++; $display("FAIL clr_alone: fault=%b dir=%b cyc=%0d want 0 00 1",
                            fault, fault_dir, ns_cycles);
        end
        drive(C_G, C_R, 1'b0);
        drive(C_Y, C_R, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({fault, fault_dir, ns_cycles, dwell_ns, dwell_ew} !== 23'd0) begin
            bad++; $display("FAIL async_reset: fault=%b dir=%b cyc=%0d dns=%0d dew=%0d want all 0",
                            fault, fault_dir, ns_cycles, dwell_ns, dwell_ew);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(C_Y, C_R, 1'b0);
        total++;
        if (fault !== 1'b0 || dwell_ns !== 6'd1) begin
            bad++; $display("FAIL post_reset_init: fault=%b dwell=%0d want 0 1", fault, dwell_ns);
        end
    endtask

    function automatic logic [2:0] pick(input logic [2:0] cur);
        int r;
        r = $urandom_range(0, 99);
        if (cur >= 1 && cur <= 3 && r < 88) return cur;
        if (r < 97) begin
            if (cur >= 1 && cur <= 3) return 3'((int'(cur) % 3) + 1);
            return 3'($urandom_range(1, 3));
        end
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [2:0] ns, ew;
        logic clr;
        do_reset();
        ns = C_R; ew = C_R;
        for (int i = 0; i < 600; i++) begin
            ns  = pick(ns);
            ew  = pick(ew);
            clr = ($urandom_range(0, 99) < 5);
            drive(ns, ew, clr);
            total++;
            if ({fault_conflict, fault_code, fault_seq, fault_timing} !== {e_conf, e_code, e_seq, e_tim}) begin
                bad++; $display("FAIL rnd_flags step %0d: got %b want %b", i,
                                {fault_conflict, fault_code, fault_seq, fault_timing},
                                {e_conf, e_code, e_seq, e_tim});
            end
            total++;
            if (fault !== (e_conf | e_code | e_seq | e_tim) || fault_dir !== e_dir) begin
                bad++; $display("FAIL rnd_dir step %0d: fault=%b dir=%b want %b %b", i, fault,
                                fault_dir, e_conf | e_code | e_seq | e_tim, e_dir);
            end
            total++;
            if (ns_cycles !== 8'(e_cyc) || dwell_ns !== 6'(m_len[0]) || dwell_ew !== 6'(m_len[1])) begin
                bad++; $display("FAIL rnd_counts step %0d: cyc=%0d dns=%0d dew=%0d want %0d %0d %0d",
                                i, ns_cycles, dwell_ns, dwell_ew, e_cyc, m_len[0], m_len[1]);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.light_ns   = C_R;
        bus.light_ew   = C_R;
        bus.clr_faults = 1'b0;
        model_reset();
        test_reset();
        test_clean_run();
        test_conflict();
        test_seq_skip();
        test_green_overrun();
        test_invalid_code();
        test_clear_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
